// File: rtl/sme_pkg.sv
// Shared constants and state encoding for the SME match engine array.
package sme_pkg;

  localparam int BYTE        = 8;
  localparam int MAX_STRING  = 32;
  localparam int MAX_STR_ADD = 5;
  localparam int MAX_PATTERN = 8;
  localparam int MAX_PAT_ADD = 3;
  localparam int NUM_SLAVE   = 4;

  // Length fields carry one extra bit so a full buffer (32 / 8) is representable.
  localparam int STR_LEN_W = MAX_STR_ADD + 1;
  localparam int PAT_LEN_W = MAX_PAT_ADD + 1;

  localparam logic [BYTE-1:0] WILDCARD_CHAR = 8'h2E;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } sme_state_e;

endpackage

// File: rtl/sme_match_engine_if.sv
// Request/result bundle between the SME controller (master) and one match engine (slave).
// start is a request strobe sampled only while the engine is idle (busy=0); there is no
// ready back-pressure -- a start seen while busy is dropped. done is a one-cycle pulse
// marking match/match_index valid; both stay held until the next accepted start.
// state mirrors the engine FSM for observation only.
interface sme_match_engine_if;
  import sme_pkg::*;

  logic                          start;
  logic [MAX_STRING*BYTE-1:0]    str_reg;
  logic [MAX_PATTERN*BYTE-1:0]   pat_reg;
  logic [STR_LEN_W-1:0]          str_len;
  logic [PAT_LEN_W-1:0]          pat_len;
  logic                          busy;
  logic                          done;
  logic                          match;
  logic [MAX_STR_ADD-1:0]        match_index;
  sme_state_e                    state;

  modport master (
    output start, str_reg, pat_reg, str_len, pat_len,
    input  busy, done, match, match_index, state
  );

  modport slave (
    input  start, str_reg, pat_reg, str_len, pat_len,
    output busy, done, match, match_index, state
  );
endinterface

// File: rtl/sme_window_cmp.sv
// Combinational compare of one string window against the pattern.
// Optional macro SME_WILDCARD_EN: pattern byte 8'h2E matches any string byte.
module sme_window_cmp
  import sme_pkg::*;
(
  input  logic [MAX_STRING*BYTE-1:0]  str_i,
  input  logic [MAX_PATTERN*BYTE-1:0] pat_i,
  input  logic [MAX_STR_ADD-1:0]      pos_i,
  input  logic [PAT_LEN_W-1:0]        pat_len_i,
  output logic                        hit_o
);

  logic [STR_LEN_W-1:0] idx;
  logic [BYTE-1:0]      s_byte;
  logic [BYTE-1:0]      p_byte;
  logic                 byte_eq;

  // Every pattern byte below pat_len must agree with the string byte at pos+i.
  always_comb begin
    hit_o   = 1'b1;
    idx     = '0;
    s_byte  = '0;
    p_byte  = '0;
    byte_eq = 1'b0;
    for (int i = 0; i < MAX_PATTERN; i++) begin
      idx    = {1'b0, pos_i} + STR_LEN_W'(i);
      s_byte = str_i[idx[MAX_STR_ADD-1:0]*BYTE +: BYTE];
      p_byte = pat_i[i*BYTE +: BYTE];
`ifdef SME_WILDCARD_EN
      byte_eq = !idx[MAX_STR_ADD] && ((s_byte == p_byte) || (p_byte == WILDCARD_CHAR));
`else
      byte_eq = !idx[MAX_STR_ADD] && (s_byte == p_byte);
`endif
      // idx past byte 31 only arises for bytes beyond pat_len, which are masked here.
      if ((PAT_LEN_W'(i) < pat_len_i) && !byte_eq) hit_o = 1'b0;
    end
  end

endmodule

// File: rtl/sme_match_engine.sv
// Sequential first-occurrence pattern search, one start position per cycle.
// Optional macro SME_WILDCARD_EN (handled in sme_window_cmp): '.' in the pattern is a wildcard.
module sme_match_engine
  import sme_pkg::*;
(
  input logic              clk,
  input logic              reset,
  sme_match_engine_if.slave bus
);

  sme_state_e                  state_q, state_d;
  logic [MAX_STRING*BYTE-1:0]  str_q, str_d;
  logic [MAX_PATTERN*BYTE-1:0] pat_q, pat_d;
  logic [STR_LEN_W-1:0]        str_len_q, str_len_d;
  logic [PAT_LEN_W-1:0]        pat_len_q, pat_len_d;
  logic [MAX_STR_ADD-1:0]      pos_q, pos_d;
  logic [STR_LEN_W-1:0]        last_q, last_d;
  logic                        match_q, match_d;
  logic [MAX_STR_ADD-1:0]      match_index_q, match_index_d;
  logic                        hit;
  logic                        degenerate;

  sme_window_cmp u_cmp (
    .str_i     (str_q),
    .pat_i     (pat_q),
    .pos_i     (pos_q),
    .pat_len_i (pat_len_q),
    .hit_o     (hit)
  );

  // Requests that can never produce a valid window finish without scanning.
  assign degenerate = (bus.pat_len == '0)
                   || (bus.pat_len > PAT_LEN_W'(MAX_PATTERN))
                   || (bus.str_len > STR_LEN_W'(MAX_STRING))
                   || (STR_LEN_W'(bus.pat_len) > bus.str_len);

  // State and datapath registers; synchronous reset clears everything.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      str_q         <= '0;
      pat_q         <= '0;
      str_len_q     <= '0;
      pat_len_q     <= '0;
      pos_q         <= '0;
      last_q        <= '0;
      match_q       <= 1'b0;
      match_index_q <= '0;
    end else begin
      state_q       <= state_d;
      str_q         <= str_d;
      pat_q         <= pat_d;
      str_len_q     <= str_len_d;
      pat_len_q     <= pat_len_d;
      pos_q         <= pos_d;
      last_q        <= last_d;
      match_q       <= match_d;
      match_index_q <= match_index_d;
    end
  end

  // Next-state and datapath update for IDLE -> SCAN -> DONE.
  always_comb begin
    state_d       = state_q;
    str_d         = str_q;
    pat_d         = pat_q;
    str_len_d     = str_len_q;
    pat_len_d     = pat_len_q;
    pos_d         = pos_q;
    last_d        = last_q;
    match_d       = match_q;
    match_index_d = match_index_q;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          str_d         = bus.str_reg;
          pat_d         = bus.pat_reg;
          str_len_d     = bus.str_len;
          pat_len_d     = bus.pat_len;
          match_d       = 1'b0;
          match_index_d = '0;
          pos_d         = '0;
          last_d        = bus.str_len - STR_LEN_W'(bus.pat_len);
          state_d       = degenerate ? DONE : SCAN;
        end
      end
      SCAN: begin
        if (hit) begin
          match_d       = 1'b1;
          match_index_d = pos_q;
          state_d       = DONE;
        end else if ({1'b0, pos_q} == last_q) begin
          state_d = DONE;
        end else begin
          pos_d = pos_q + MAX_STR_ADD'(1);
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign bus.busy        = (state_q != IDLE);
  assign bus.done        = (state_q == DONE);
  assign bus.match       = match_q;
  assign bus.match_index = match_index_q;
  assign bus.state       = state_q;

endmodule

// File: tb/tb_sme_match_engine.sv
// Directed plus randomized bench for sme_match_engine, checked against a
// straightforward string-search reference model.
module tb_sme_match_engine;
  import sme_pkg::*;

`ifdef SME_WILDCARD_EN
  localparam bit WILD = 1'b1;
`else
  localparam bit WILD = 1'b0;
`endif

  logic clk;
  logic reset;
  int   checks;
  int   failures;

  sme_match_engine_if bus ();

  sme_match_engine dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    assert (act === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, act, exp);
    end
  endtask

  function automatic logic [255:0] pack_str(input string t);
    logic [255:0] r;
    r = '0;
    for (int i = 0; i < t.len() && i < 32; i++) r[i*8 +: 8] = t.getc(i);
    return r;
  endfunction

  function automatic logic [63:0] pack_pat(input string t);
    logic [63:0] r;
    r = '0;
    for (int i = 0; i < t.len() && i < 8; i++) r[i*8 +: 8] = t.getc(i);
    return r;
  endfunction

  // Reference: scan every start position, first full window match wins.
  function automatic void ref_search(input logic [255:0] s, input logic [63:0] p,
                                     input int sl, input int pl,
                                     output logic m, output int idx, output int dcyc);
    logic [7:0] sb [32];
    logic [7:0] pb [8];
    bit ok;
    for (int i = 0; i < 32; i++) sb[i] = s[i*8 +: 8];
    for (int i = 0; i < 8; i++)  pb[i] = p[i*8 +: 8];
    m = 1'b0;
    idx = 0;
    if (pl == 0 || pl > 8 || sl > 32 || pl > sl) begin
      dcyc = 1;
      return;
    end
    dcyc = sl - pl + 2;
    for (int q = 0; q <= sl - pl; q++) begin
      ok = 1'b1;
      for (int j = 0; j < pl; j++)
        if (!(sb[q+j] == pb[j] || (WILD && pb[j] == 8'h2E))) ok = 1'b0;
      if (ok) begin
        m = 1'b1;
        idx = q;
        dcyc = q + 2;
        break;
      end
    end
  endfunction

  // Driver: issue one request, scramble inputs afterwards, optionally re-pulse
  // start at cycle 'poke', then check timing and results against the model.
  task automatic run_search(input string tag, input logic [255:0] s, input logic [63:0] p,
                            input logic [5:0] sl, input logic [3:0] pl, input int poke);
    logic em;
    int   ei;
    int   ed;
    int   cyc;
    ref_search(s, p, int'(sl), int'(pl), em, ei, ed);
    @(negedge clk);
    bus.start   = 1'b1;
    bus.str_reg = s;
    bus.pat_reg = p;
    bus.str_len = sl;
    bus.pat_len = pl;
    @(posedge clk); #1;
    bus.start   = 1'b0;
    bus.str_reg = {8{$urandom()}};
    bus.pat_reg = {$urandom(), $urandom()};
    bus.str_len = 6'($urandom_range(0, 63));
    bus.pat_len = 4'($urandom_range(0, 15));
    cyc = 1;
    check({tag, ":busy_c1"}, 32'(bus.busy), 1);
    check({tag, ":match_clr"}, 32'(bus.match), 0);
    check({tag, ":idx_clr"}, 32'(bus.match_index), 0);
    while (!bus.done && cyc < 80) begin
      bus.start = (cyc == poke);
      @(posedge clk); #1;
      cyc++;
    end
    bus.start = 1'b0;
    check({tag, ":done_cycle"}, 32'(cyc), 32'(ed));
    check({tag, ":match"}, 32'(bus.match), 32'(em));
    check({tag, ":index"}, 32'(bus.match_index), 32'(ei));
    check({tag, ":busy_done"}, 32'(bus.busy), 1);
    @(posedge clk); #1;
    check({tag, ":done_pulse"}, 32'(bus.done), 0);
    check({tag, ":busy_idle"}, 32'(bus.busy), 0);
    check({tag, ":match_held"}, 32'(bus.match), 32'(em));
    check({tag, ":index_held"}, 32'(bus.match_index), 32'(ei));
  endtask

  initial begin : stim
    logic [255:0] s;
    logic [63:0]  p;
    logic [7:0]   ch;
    int           cyc;
    checks   = 0;
    failures = 0;
    bus.start   = 1'b0;
    bus.str_reg = '0;
    bus.pat_reg = '0;
    bus.str_len = '0;
    bus.pat_len = '0;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst:busy", 32'(bus.busy), 0);
    check("rst:done", 32'(bus.done), 0);
    check("rst:match", 32'(bus.match), 0);
    check("rst:index", 32'(bus.match_index), 0);
    check("rst:state", 32'(bus.state), 0);
    @(negedge clk);
    reset = 1'b0;

    // Directed scenarios
    run_search("hello_wor", pack_str("HELLOWORLD"), pack_pat("WOR"), 6'd10, 4'd3, 0);
    run_search("hello_xyz", pack_str("HELLOWORLD"), pack_pat("XYZ"), 6'd10, 4'd3, 0);
    s = '0;
    for (int i = 0; i < 31; i++) s[i*8 +: 8] = 8'h41;
    s[31*8 +: 8] = 8'h42;
    run_search("a31b", s, pack_pat("AB"), 6'd32, 4'd2, 10);
    run_search("deg_pl0", pack_str("HELLOWORLD"), pack_pat("WOR"), 6'd10, 4'd0, 0);
    run_search("deg_pl9", pack_str("HELLOWORLD"), pack_pat("WOR"), 6'd10, 4'd9, 0);
    run_search("deg_pl_gt_sl", pack_str("HELLOWORLD"), pack_pat("HELL"), 6'd3, 4'd4, 0);
    run_search("deg_sl33", pack_str("HELLOWORLD"), pack_pat("H"), 6'd33, 4'd1, 0);
    run_search("full_len", pack_str("HELLOWORLD"), pack_pat("HELLOWOR"), 6'd8, 4'd8, 0);
    // Model decides: hit at 5 with the wildcard build, literal miss otherwise.
    run_search("wild_wdr", pack_str("HELLOWORLD"), pack_pat("W.R"), 6'd10, 4'd3, 0);

    // Reset in the middle of a scan
    @(negedge clk);
    bus.start   = 1'b1;
    bus.str_reg = pack_str("HELLOWORLD");
    bus.pat_reg = pack_pat("WOR");
    bus.str_len = 6'd10;
    bus.pat_len = 4'd3;
    @(posedge clk); #1;
    bus.start = 1'b0;
    for (cyc = 1; cyc < 4; cyc++) begin
      check("rst_mid:no_done", 32'(bus.done), 0);
      @(posedge clk); #1;
    end
    reset = 1'b1;
    check("rst_mid:busy_c4", 32'(bus.busy), 1);
    @(posedge clk); #1;
    check("rst_mid:busy", 32'(bus.busy), 0);
    check("rst_mid:done", 32'(bus.done), 0);
    check("rst_mid:match", 32'(bus.match), 0);
    check("rst_mid:state", 32'(bus.state), 0);
    reset = 1'b0;
    run_search("after_rst", pack_str("HELLOWORLD"), pack_pat("WOR"), 6'd10, 4'd3, 0);

    // Randomized requests over a small alphabet so hits are common
    for (int n = 0; n < 40; n++) begin
      for (int i = 0; i < 32; i++) s[i*8 +: 8] = ($urandom_range(0, 2) == 0) ? 8'h42 : 8'h41;
      for (int i = 0; i < 8; i++) begin
        ch = ($urandom_range(0, 5) == 0) ? 8'h2E : (($urandom_range(0, 2) == 0) ? 8'h42 : 8'h41);
        p[i*8 +: 8] = ch;
      end
      run_search("rand", s, p, 6'($urandom_range(0, 34)), 4'($urandom_range(0, 9)),
                 int'($urandom_range(0, 6)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
